// File: rtl/cdc_pulse_lane_scheduler.sv
// Round-robin scheduler for the 8-lane slow-to-fast pulse synchronizer.
// Each grant produces one HIGH/LOW level event on the requested lane.
module cdc_pulse_lane_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   slow_clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_lane,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [7:0]             lane_out,
  output logic [7:0]             lane_busy,
  output logic [PW-1:0]          rr_ptr
);

  localparam int MAXC =
    (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]    st    [8];
  logic [1:0]    st_n  [8];
  logic [CW-1:0] cnt   [8];
  logic [CW-1:0] cnt_n [8];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_n;
  logic [PW-1:0]      rr_n;
  logic [7:0]         out_n;
  logic [7:0]         busy_n;
  logic               found;
  logic [2:0]         win_lane;
  int                 win;

  always_comb begin
    int idx;
    elig     = '0;
    found    = 1'b0;
    win      = 0;
    idx      = 0;
    gnt_n    = '0;
    win_lane = 3'd0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req[i] && (st[req_lane[3*i +: 3]] == S_IDLE);
    // First eligible requester at or after rr_ptr, with wrap.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      gnt_n[win] = 1'b1;
      win_lane   = req_lane[3*win +: 3];
    end
    rr_n = found ? PW'((win + 1) % NUM_REQ) : rr_ptr;
  end

  always_comb begin
    out_n  = '0;
    busy_n = '0;
    for (int l = 0; l < 8; l++) begin
      st_n[l]  = st[l];
      cnt_n[l] = cnt[l];
      unique case (1'b1)
        (st[l] == S_IDLE): begin
          if (found && win_lane == 3'(l)) begin
            st_n[l]  = S_HIGH;
            cnt_n[l] = CW'(HIGH_CYCLES - 1);
          end
        end
        (st[l] == S_HIGH): begin
          if (cnt[l] == '0) begin
            st_n[l]  = S_LOW;
            cnt_n[l] = CW'(LOW_CYCLES - 1);
          end else begin
            cnt_n[l] = cnt[l] - 1'b1;
          end
        end
        (st[l] == S_LOW): begin
          if (cnt[l] == '0) st_n[l] = S_IDLE;
          else cnt_n[l] = cnt[l] - 1'b1;
        end
        default: begin
          st_n[l]  = S_IDLE;
          cnt_n[l] = '0;
        end
      endcase
      out_n[l]  = (st_n[l] == S_HIGH);
      busy_n[l] = (st_n[l] != S_IDLE);
    end
  end

  always_ff @(posedge slow_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      lane_out  <= '0;
      lane_busy <= '0;
      rr_ptr    <= '0;
      for (int l = 0; l < 8; l++) begin
        st[l]  <= S_IDLE;
        cnt[l] <= '0;
      end
    end else begin
      gnt       <= gnt_n;
      lane_out  <= out_n;
      lane_busy <= busy_n;
      rr_ptr    <= rr_n;
      for (int l = 0; l < 8; l++) begin
        st[l]  <= st_n[l];
        cnt[l] <= cnt_n[l];
      end
    end
  end

endmodule

// File: tb/tb_cdc_pulse_lane_scheduler.sv
// Scoreboard bench for cdc_pulse_lane_scheduler.
// Stimulus queues expected grants; monitors pop them on each gnt.
module tb_cdc_pulse_lane_scheduler;

  logic        slow_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [11:0] req_lane;
  logic [3:0]  gnt;
  logic [7:0]  lane_out;
  logic [7:0]  lane_busy;
  logic [1:0]  rr_ptr;

  logic [0:0]  req1;
  logic [2:0]  req_lane1;
  logic [0:0]  gnt1;
  logic [7:0]  lane_out1;
  logic [7:0]  lane_busy1;
  logic [0:0]  rr1;

  int nv = 0;
  int nf = 0;
  int cyc = 0;
  int base;

  typedef struct {
    int         c;
    logic [3:0] g;
    logic [1:0] r;
    logic [7:0] l;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  cdc_pulse_lane_scheduler #(
    .NUM_REQ(4), .HIGH_CYCLES(2), .LOW_CYCLES(2)
  ) u0 (
    .slow_clk(slow_clk), .reset_n(reset_n),
    .req(req), .req_lane(req_lane),
    .gnt(gnt), .lane_out(lane_out),
    .lane_busy(lane_busy), .rr_ptr(rr_ptr)
  );

  cdc_pulse_lane_scheduler #(
    .NUM_REQ(1), .HIGH_CYCLES(1), .LOW_CYCLES(1)
  ) u1 (
    .slow_clk(slow_clk), .reset_n(reset_n),
    .req(req1), .req_lane(req_lane1),
    .gnt(gnt1), .lane_out(lane_out1),
    .lane_busy(lane_busy1), .rr_ptr(rr1)
  );

  always #5 slow_clk = ~slow_clk;
  always @(posedge slow_clk) cyc <= cyc + 1;

  always @(negedge slow_clk) begin
    exp_t e;
    if (reset_n && gnt != 4'd0) begin
      nv++;
      if (q0.size() == 0) begin
        nf++;
        $display("FAIL gnt0_unexpected cyc=%0d gnt=%b", cyc, gnt);
      end else begin
        e = q0.pop_front();
        if (cyc != e.c || gnt !== e.g || rr_ptr !== e.r ||
            lane_out !== e.l) begin
          nf++;
          $display("FAIL gnt0 got c=%0d g=%b r=%0d l=%h want c=%0d g=%b r=%0d l=%h",
                   cyc, gnt, rr_ptr, lane_out, e.c, e.g, e.r, e.l);
        end
      end
    end
  end

  always @(negedge slow_clk) begin
    exp_t e;
    if (reset_n && gnt1 != 1'b0) begin
      nv++;
      if (q1.size() == 0) begin
        nf++;
        $display("FAIL gnt1_unexpected cyc=%0d", cyc);
      end else begin
        e = q1.pop_front();
        if (cyc != e.c || rr1 !== e.r[0:0] || lane_out1 !== e.l) begin
          nf++;
          $display("FAIL gnt1 got c=%0d r=%0d l=%h want c=%0d r=%0d l=%h",
                   cyc, rr1, lane_out1, e.c, e.r, e.l);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge slow_clk);
  endtask

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nv++;
    if (a !== e) begin
      nf++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  function automatic void push0(input int c, input logic [3:0] g,
                                input logic [1:0] r, input logic [7:0] l);
    q0.push_back('{c, g, r, l});
  endfunction

  function automatic void push1(input int c);
    q1.push_back('{c, 4'd1, 2'd0, 8'h80});
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    req       = '0;
    req_lane  = '0;
    req1      = '0;
    req_lane1 = '0;
    tick(2);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_lane_out", 32'(lane_out), 0);
    chk("rst_busy", 32'(lane_busy), 0);
    chk("rst_rr", 32'(rr_ptr), 0);
    reset_n = 1'b1;

    // single requester on lane 3, held for two events
    base     = cyc;
    req      = 4'b0001;
    req_lane = 12'h003;
    push0(base + 1, 4'b0001, 2'd1, 8'h08);
    push0(base + 6, 4'b0001, 2'd1, 8'h08);
    tick(2);
    chk("t1_hi2_out", 32'(lane_out), 32'h08);
    chk("t1_hi2_busy", 32'(lane_busy), 32'h08);
    tick(1);
    chk("t1_lo1_out", 32'(lane_out), 0);
    chk("t1_lo1_busy", 32'(lane_busy), 32'h08);
    tick(1);
    chk("t1_lo2_busy", 32'(lane_busy), 32'h08);
    tick(1);
    chk("t1_idle_busy", 32'(lane_busy), 0);
    chk("t1_idle_gnt", 32'(gnt), 0);
    tick(1);
    req = '0;
    tick(6);

    // four requesters sharing lane 0
    do_reset();
    base     = cyc;
    req      = 4'b1111;
    req_lane = 12'h000;
    push0(base + 1,  4'b0001, 2'd1, 8'h01);
    push0(base + 6,  4'b0010, 2'd2, 8'h01);
    push0(base + 11, 4'b0100, 2'd3, 8'h01);
    push0(base + 16, 4'b1000, 2'd0, 8'h01);
    tick(16);
    req = '0;
    tick(6);

    // four requesters on lanes 0..3
    do_reset();
    base     = cyc;
    req      = 4'b1111;
    req_lane = {3'd3, 3'd2, 3'd1, 3'd0};
    push0(base + 1, 4'b0001, 2'd1, 8'h01);
    push0(base + 2, 4'b0010, 2'd2, 8'h03);
    push0(base + 3, 4'b0100, 2'd3, 8'h06);
    push0(base + 4, 4'b1000, 2'd0, 8'h0C);
    tick(4);
    req = '0;
    tick(1);
    chk("t3_step5", 32'(lane_out), 32'h08);
    tick(1);
    chk("t3_step6", 32'(lane_out), 0);
    tick(4);

    // requester 2 withdraws before its turn
    do_reset();
    base     = cyc;
    req      = 4'b1111;
    req_lane = 12'h000;
    push0(base + 1,  4'b0001, 2'd1, 8'h01);
    push0(base + 6,  4'b0010, 2'd2, 8'h01);
    push0(base + 11, 4'b1000, 2'd0, 8'h01);
    tick(8);
    req[2] = 1'b0;
    tick(3);
    req = '0;
    tick(6);

    // reset during lane 5 HIGH phase
    do_reset();
    base     = cyc;
    req      = 4'b0001;
    req_lane = 12'd5;
    push0(base + 1, 4'b0001, 2'd1, 8'h20);
    tick(2);
    chk("t5_pre_out", 32'(lane_out), 32'h20);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_out", 32'(lane_out), 0);
    chk("t5_rst_gnt", 32'(gnt), 0);
    chk("t5_rst_rr", 32'(rr_ptr), 0);
    chk("t5_rst_busy", 32'(lane_busy), 0);
    tick(1);
    reset_n = 1'b1;
    push0(base + 4, 4'b0001, 2'd1, 8'h20);
    tick(1);
    req = '0;
    tick(6);

    // HIGH=1, LOW=1, single requester on lane 7
    do_reset();
    base      = cyc;
    req1      = 1'b1;
    req_lane1 = 3'd7;
    push1(base + 1);
    push1(base + 4);
    push1(base + 7);
    push1(base + 10);
    tick(2);
    chk("t6_lo1", 32'(lane_out1), 0);
    chk("t6_busy1", 32'(lane_busy1), 32'h80);
    tick(1);
    chk("t6_lo2", 32'(lane_out1), 0);
    chk("t6_idle", 32'(lane_busy1), 0);
    tick(7);
    req1 = '0;
    tick(4);

    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
    $finish;
  end

endmodule
